// File: rtl/fetch_decode_queue_pkg.sv
// Shared codes and decoded-entry layout for the 6502 fetch/decode front end.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package fetch_decode_queue_pkg;

  // Addressing-mode codes
  localparam logic [1:0] MODE_IMP = 2'd0;
  localparam logic [1:0] MODE_IMM = 2'd1;
  localparam logic [1:0] MODE_ZP  = 2'd2;
  localparam logic [1:0] MODE_ABS = 2'd3;

  // Instruction-type codes
  localparam logic [3:0] TYPE_NONE   = 4'd0;
  localparam logic [3:0] TYPE_ALU    = 4'd1;
  localparam logic [3:0] TYPE_LOAD   = 4'd2;
  localparam logic [3:0] TYPE_STORE  = 4'd3;
  localparam logic [3:0] TYPE_JUMP   = 4'd4;
  localparam logic [3:0] TYPE_BRANCH = 4'd5;
  localparam logic [3:0] TYPE_RMW    = 4'd6;
  localparam logic [3:0] TYPE_SHIFT  = 4'd7;
  localparam logic [3:0] TYPE_INDEX  = 4'd8;

  // Destination (or, for stores, source) register codes
  localparam logic [2:0] DEST_NONE = 3'd0;
  localparam logic [2:0] DEST_A    = 3'd1;
  localparam logic [2:0] DEST_X    = 3'd2;
  localparam logic [2:0] DEST_Y    = 3'd3;
  localparam logic [2:0] DEST_MEM  = 3'd4;

  // ALU operation codes understood by the execute stage
  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_EOR = 5'd4;
  localparam logic [4:0] ALU_ORA = 5'd5;
  localparam logic [4:0] ALU_ASL = 5'd6;
  localparam logic [4:0] ALU_ROL = 5'd7;
  localparam logic [4:0] ALU_LSR = 5'd8;
  localparam logic [4:0] ALU_ROR = 5'd9;
  localparam logic [4:0] ALU_INC = 5'd10;
  localparam logic [4:0] ALU_DEC = 5'd11;

  // Decoded-entry field widths
  localparam int OPCODE_W  = 8;
  localparam int OPERAND_W = 16;

  typedef struct packed {
    logic [4:0] alu_op;
    logic       use_alu;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] addr_mode;
    logic [1:0] instr_size;
    logic [3:0] instr_type;
    logic [2:0] reg_dest;
    logic       illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_OP   = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  // Instruction length follows directly from the addressing mode.
  function automatic logic [1:0] mode_size(input logic [1:0] mode);
    case (mode)
      MODE_IMP: return 2'd1;
      MODE_ABS: return 2'd3;
      default:  return 2'd2;
    endcase
  endfunction

  function automatic dec_t mk_dec(input logic [4:0] alu_op, input logic use_alu,
                                  input logic mem_read, input logic mem_write,
                                  input logic [1:0] mode, input logic [3:0] itype,
                                  input logic [2:0] dest);
    dec_t d;
    d.alu_op     = alu_op;
    d.use_alu    = use_alu;
    d.mem_read   = mem_read;
    d.mem_write  = mem_write;
    d.addr_mode  = mode;
    d.instr_size = mode_size(mode);
    d.instr_type = itype;
    d.reg_dest   = dest;
    d.illegal    = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_opcode_decode.sv
// Opcode-to-control-bundle decoder for the supported 6502 subset.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the opcode input directly.
module opcode_decode
  import fetch_decode_queue_pkg::*;
#(
  parameter int ENABLE_ABS = 1
) (
  input  logic [7:0] opcode,
  output dec_t       dec
);

  // Unknown opcodes fall through as single-byte illegal entries with no side effects.
  always_comb begin
    dec            = '0;
    dec.instr_size = 2'd1;
    dec.illegal    = 1'b1;
    case (opcode)
      8'h0A: dec = mk_dec(ALU_ASL, 1'b1, 1'b0, 1'b0, MODE_IMP, TYPE_SHIFT, DEST_A);
      8'h2A: dec = mk_dec(ALU_ROL, 1'b1, 1'b0, 1'b0, MODE_IMP, TYPE_SHIFT, DEST_A);
      8'h4A: dec = mk_dec(ALU_LSR, 1'b1, 1'b0, 1'b0, MODE_IMP, TYPE_SHIFT, DEST_A);
      8'h6A: dec = mk_dec(ALU_ROR, 1'b1, 1'b0, 1'b0, MODE_IMP, TYPE_SHIFT, DEST_A);
      8'hA9: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b0, MODE_IMM, TYPE_LOAD, DEST_A);
      8'hA5: dec = mk_dec(ALU_NOP, 1'b0, 1'b1, 1'b0, MODE_ZP,  TYPE_LOAD, DEST_A);
      8'hA2: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b0, MODE_IMM, TYPE_LOAD, DEST_X);
      8'hA6: dec = mk_dec(ALU_NOP, 1'b0, 1'b1, 1'b0, MODE_ZP,  TYPE_LOAD, DEST_X);
      8'hA0: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b0, MODE_IMM, TYPE_LOAD, DEST_Y);
      8'hA4: dec = mk_dec(ALU_NOP, 1'b0, 1'b1, 1'b0, MODE_ZP,  TYPE_LOAD, DEST_Y);
      // Stores carry the source register in reg_dest.
      8'h85: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b1, MODE_ZP, TYPE_STORE, DEST_A);
      8'h86: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b1, MODE_ZP, TYPE_STORE, DEST_X);
      8'h84: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b1, MODE_ZP, TYPE_STORE, DEST_Y);
      8'h69: dec = mk_dec(ALU_ADD, 1'b1, 1'b0, 1'b0, MODE_IMM, TYPE_ALU, DEST_A);
      8'hE9: dec = mk_dec(ALU_SUB, 1'b1, 1'b0, 1'b0, MODE_IMM, TYPE_ALU, DEST_A);
      8'h29: dec = mk_dec(ALU_AND, 1'b1, 1'b0, 1'b0, MODE_IMM, TYPE_ALU, DEST_A);
      8'h49: dec = mk_dec(ALU_EOR, 1'b1, 1'b0, 1'b0, MODE_IMM, TYPE_ALU, DEST_A);
      8'h09: dec = mk_dec(ALU_ORA, 1'b1, 1'b0, 1'b0, MODE_IMM, TYPE_ALU, DEST_A);
      8'h45: dec = mk_dec(ALU_EOR, 1'b1, 1'b1, 1'b0, MODE_ZP, TYPE_ALU, DEST_A);
      8'h05: dec = mk_dec(ALU_ORA, 1'b1, 1'b1, 1'b0, MODE_ZP, TYPE_ALU, DEST_A);
      8'hE6: dec = mk_dec(ALU_INC, 1'b1, 1'b1, 1'b1, MODE_ZP, TYPE_RMW, DEST_MEM);
      8'hC6: dec = mk_dec(ALU_DEC, 1'b1, 1'b1, 1'b1, MODE_ZP, TYPE_RMW, DEST_MEM);
      8'h4C: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b0, MODE_ABS, TYPE_JUMP, DEST_NONE);
      // Relative branch offsets travel as a one-byte immediate.
      8'hF0: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b0, MODE_IMM, TYPE_BRANCH, DEST_NONE);
      8'hD0: dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b0, MODE_IMM, TYPE_BRANCH, DEST_NONE);
      8'hE8: dec = mk_dec(ALU_INC, 1'b1, 1'b0, 1'b0, MODE_IMP, TYPE_INDEX, DEST_X);
      8'hCA: dec = mk_dec(ALU_DEC, 1'b1, 1'b0, 1'b0, MODE_IMP, TYPE_INDEX, DEST_X);
      8'h88: dec = mk_dec(ALU_DEC, 1'b1, 1'b0, 1'b0, MODE_IMP, TYPE_INDEX, DEST_Y);
      8'hC8: dec = mk_dec(ALU_INC, 1'b1, 1'b0, 1'b0, MODE_IMP, TYPE_INDEX, DEST_Y);
      8'hAD: if (ENABLE_ABS != 0) dec = mk_dec(ALU_NOP, 1'b0, 1'b1, 1'b0, MODE_ABS, TYPE_LOAD, DEST_A);
      8'hAE: if (ENABLE_ABS != 0) dec = mk_dec(ALU_NOP, 1'b0, 1'b1, 1'b0, MODE_ABS, TYPE_LOAD, DEST_X);
      8'h8D: if (ENABLE_ABS != 0) dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b1, MODE_ABS, TYPE_STORE, DEST_A);
      8'h8E: if (ENABLE_ABS != 0) dec = mk_dec(ALU_NOP, 1'b0, 1'b0, 1'b1, MODE_ABS, TYPE_STORE, DEST_X);
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetches 6502 instruction bytes, assembles opcode+operands, decodes and queues entries.
// Latency: entry is visible on out_valid the cycle after its last byte is accepted.
// Backpressure: full queue parks the finished entry in HOLD with fetch_req low; flush empties.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,   // power of two, >= 2
  parameter int          ADDR_W      = 16,
  parameter int unsigned RESET_PC    = 0,
  parameter int          ENABLE_ABS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic [7:0]        fetch_data,
  input  logic              fetch_valid,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [7:0]        out_opcode,
  output logic [15:0]       out_operand,
  output logic [4:0]        out_alu_op,
  output logic              out_use_alu,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [1:0]        out_addr_mode,
  output logic [1:0]        out_instr_size,
  output logic [3:0]        out_instr_type,
  output logic [2:0]        out_reg_dest,
  output logic              out_illegal
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;
    dec_t                 dec;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;       // next byte address
  logic [ADDR_W-1:0] ipc_q;      // address of the current instruction's opcode
  logic [7:0]        op_q;       // opcode of the instruction being assembled
  logic [7:0]        lo_q;       // operand low byte
  entry_t            hold_q;     // finished entry waiting for queue space

  entry_t            mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              accept, pop, space, instr_done, push;
  logic [7:0]        dec_opcode;
  dec_t              dec_w;
  entry_t            new_entry, push_entry, head_entry;

  assign fetch_req  = !rst && (state_q != ST_HOLD);
  assign fetch_addr = pc_q;
  assign accept     = fetch_req && fetch_valid;

  // In OP the returning byte is decoded directly; later bytes reuse the latched opcode.
  assign dec_opcode = (state_q == ST_OP) ? fetch_data : op_q;

  opcode_decode #(
    .ENABLE_ABS (ENABLE_ABS)
  ) u_decode (
    .opcode (dec_opcode),
    .dec    (dec_w)
  );

  assign out_valid = !rst && (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees a slot, so a full queue can still accept.
  assign space     = (count_q < CNT_W'(QUEUE_DEPTH)) || pop;

  // Next-state and entry assembly for the byte being accepted this cycle.
  always_comb begin
    state_d           = state_q;
    instr_done        = 1'b0;
    new_entry.pc      = ipc_q;
    new_entry.opcode  = op_q;
    new_entry.operand = '0;
    new_entry.dec     = dec_w;
    case (state_q)
      ST_OP: begin
        new_entry.pc     = pc_q;
        new_entry.opcode = fetch_data;
        if (accept) begin
          if (dec_w.instr_size == 2'd1) instr_done = 1'b1;
          else                          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        new_entry.operand = {8'h00, fetch_data};
        if (accept) begin
          if (dec_w.instr_size == 2'd2) instr_done = 1'b1;
          else                          state_d    = ST_HI;
        end
      end
      ST_HI: begin
        new_entry.operand = {fetch_data, lo_q};
        if (accept) instr_done = 1'b1;
      end
      ST_HOLD: begin
        if (space) state_d = ST_OP;
      end
      default: state_d = ST_OP;
    endcase
    if (instr_done) state_d = space ? ST_OP : ST_HOLD;
    if (flush)      state_d = ST_OP;
  end

  assign push       = (instr_done || (state_q == ST_HOLD)) && space && !flush && !rst;
  assign push_entry = (state_q == ST_HOLD) ? hold_q : new_entry;

  // Fetch state and program counter; flush redirects and drops any byte accepted with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OP;
      pc_q    <= ADDR_W'(RESET_PC);
    end else if (flush) begin
      state_q <= ST_OP;
      pc_q    <= flush_pc;
    end else begin
      state_q <= state_d;
      if (accept) pc_q <= pc_q + ADDR_W'(1);
    end
  end

  // Partial-instruction bytes and the parked entry; stale contents are harmless after reset.
  always_ff @(posedge clk) begin
    if (accept && (state_q == ST_OP)) begin
      op_q  <= fetch_data;
      ipc_q <= pc_q;
    end
    if (accept && (state_q == ST_LO)) lo_q <= fetch_data;
    if (instr_done && !space) hold_q <= new_entry;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_entry;
  end

  // Head fields are forced to zero while empty or in reset.
  assign head_entry     = out_valid ? mem_q[head_q] : '0;
  assign out_pc         = head_entry.pc;
  assign out_opcode     = head_entry.opcode;
  assign out_operand    = head_entry.operand;
  assign out_alu_op     = head_entry.dec.alu_op;
  assign out_use_alu    = head_entry.dec.use_alu;
  assign out_mem_read   = head_entry.dec.mem_read;
  assign out_mem_write  = head_entry.dec.mem_write;
  assign out_addr_mode  = head_entry.dec.addr_mode;
  assign out_instr_size = head_entry.dec.instr_size;
  assign out_instr_type = head_entry.dec.instr_type;
  assign out_reg_dest   = head_entry.dec.reg_dest;
  assign out_illegal    = head_entry.dec.illegal;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: three instances (default, no-abs, wrap PC).
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: exercises full-queue HOLD, flush and memory stalls.
module tb_fetch_decode_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- instance A: defaults ----------------
  logic a_rst, a_fetch_req, a_fetch_valid, a_flush, a_out_valid, a_out_ready;
  logic [15:0] a_fetch_addr, a_flush_pc, a_out_pc, a_out_operand;
  logic [7:0] a_fetch_data, a_out_opcode;
  logic [4:0] a_out_alu_op;
  logic a_out_use_alu, a_out_mem_read, a_out_mem_write, a_out_illegal;
  logic [1:0] a_out_addr_mode, a_out_instr_size;
  logic [3:0] a_out_instr_type;
  logic [2:0] a_out_reg_dest;
  logic [7:0] mem_a [256];
  assign a_fetch_data = mem_a[a_fetch_addr[7:0]];

  fetch_decode_queue #(.QUEUE_DEPTH(4), .ADDR_W(16), .RESET_PC(0), .ENABLE_ABS(1)) u_a (
    .clk(clk), .rst(a_rst), .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr),
    .fetch_data(a_fetch_data), .fetch_valid(a_fetch_valid), .flush(a_flush),
    .flush_pc(a_flush_pc), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_opcode(a_out_opcode), .out_operand(a_out_operand),
    .out_alu_op(a_out_alu_op), .out_use_alu(a_out_use_alu), .out_mem_read(a_out_mem_read),
    .out_mem_write(a_out_mem_write), .out_addr_mode(a_out_addr_mode),
    .out_instr_size(a_out_instr_size), .out_instr_type(a_out_instr_type),
    .out_reg_dest(a_out_reg_dest), .out_illegal(a_out_illegal));

  // ---------------- instance B: absolute mode disabled ----------------
  logic b_rst, b_fetch_req, b_fetch_valid, b_flush, b_out_valid, b_out_ready;
  logic [15:0] b_fetch_addr, b_flush_pc, b_out_pc, b_out_operand;
  logic [7:0] b_fetch_data, b_out_opcode;
  logic [4:0] b_out_alu_op;
  logic b_out_use_alu, b_out_mem_read, b_out_mem_write, b_out_illegal;
  logic [1:0] b_out_addr_mode, b_out_instr_size;
  logic [3:0] b_out_instr_type;
  logic [2:0] b_out_reg_dest;
  logic [7:0] mem_b [256];
  assign b_fetch_data = mem_b[b_fetch_addr[7:0]];

  fetch_decode_queue #(.QUEUE_DEPTH(4), .ADDR_W(16), .RESET_PC(0), .ENABLE_ABS(0)) u_b (
    .clk(clk), .rst(b_rst), .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr),
    .fetch_data(b_fetch_data), .fetch_valid(b_fetch_valid), .flush(b_flush),
    .flush_pc(b_flush_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_opcode(b_out_opcode), .out_operand(b_out_operand),
    .out_alu_op(b_out_alu_op), .out_use_alu(b_out_use_alu), .out_mem_read(b_out_mem_read),
    .out_mem_write(b_out_mem_write), .out_addr_mode(b_out_addr_mode),
    .out_instr_size(b_out_instr_size), .out_instr_type(b_out_instr_type),
    .out_reg_dest(b_out_reg_dest), .out_illegal(b_out_illegal));

  // ---------------- instance C: reset PC near the top of memory ----------------
  logic c_rst, c_fetch_req, c_fetch_valid, c_flush, c_out_valid, c_out_ready;
  logic [15:0] c_fetch_addr, c_flush_pc, c_out_pc, c_out_operand;
  logic [7:0] c_fetch_data, c_out_opcode;
  logic [4:0] c_out_alu_op;
  logic c_out_use_alu, c_out_mem_read, c_out_mem_write, c_out_illegal;
  logic [1:0] c_out_addr_mode, c_out_instr_size;
  logic [3:0] c_out_instr_type;
  logic [2:0] c_out_reg_dest;
  logic [7:0] mem_c [256];
  assign c_fetch_data = mem_c[c_fetch_addr[7:0]];

  fetch_decode_queue #(.QUEUE_DEPTH(4), .ADDR_W(16), .RESET_PC(16'hFFFE), .ENABLE_ABS(1)) u_c (
    .clk(clk), .rst(c_rst), .fetch_req(c_fetch_req), .fetch_addr(c_fetch_addr),
    .fetch_data(c_fetch_data), .fetch_valid(c_fetch_valid), .flush(c_flush),
    .flush_pc(c_flush_pc), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_pc(c_out_pc), .out_opcode(c_out_opcode), .out_operand(c_out_operand),
    .out_alu_op(c_out_alu_op), .out_use_alu(c_out_use_alu), .out_mem_read(c_out_mem_read),
    .out_mem_write(c_out_mem_write), .out_addr_mode(c_out_addr_mode),
    .out_instr_size(c_out_instr_size), .out_instr_type(c_out_instr_type),
    .out_reg_dest(c_out_reg_dest), .out_illegal(c_out_illegal));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Advance until the selected instance shows a queue head, bounded.
  task automatic wait_entry(input int which, input string tag);
    logic v;
    v = 1'b0;
    for (int i = 0; i < 40 && !v; i++) begin
      step();
      case (which)
        0:       v = a_out_valid;
        1:       v = b_out_valid;
        default: v = c_out_valid;
      endcase
    end
    chk({tag, " out_valid"}, 32'(v), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic found, stall;
    logic [15:0] held;

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'hE8;
      mem_b[i] = 8'hE8;
      mem_c[i] = 8'hE8;
    end
    // A9 05 | 69 03 | E8 | 4C 34 12 | 02 | AD 00 20 | E8...
    mem_a[0] = 8'hA9; mem_a[1] = 8'h05; mem_a[2] = 8'h69; mem_a[3]  = 8'h03;
    mem_a[4] = 8'hE8; mem_a[5] = 8'h4C; mem_a[6] = 8'h34; mem_a[7]  = 8'h12;
    mem_a[8] = 8'h02; mem_a[9] = 8'hAD; mem_a[10] = 8'h00; mem_a[11] = 8'h20;
    mem_b[0] = 8'hAD; mem_b[1] = 8'h00; mem_b[2] = 8'h20;
    mem_c[8'hFE] = 8'hA9; mem_c[8'hFF] = 8'h77; mem_c[0] = 8'hA9; mem_c[1] = 8'h11;

    a_rst = 1; a_fetch_valid = 1; a_flush = 0; a_flush_pc = '0; a_out_ready = 1;
    b_rst = 1; b_fetch_valid = 1; b_flush = 0; b_flush_pc = '0; b_out_ready = 1;
    c_rst = 1; c_fetch_valid = 0; c_flush = 0; c_flush_pc = '0; c_out_ready = 1;

    repeat (3) step();
    chk("rst fetch_req", 32'(a_fetch_req), 32'h0);
    chk("rst out_valid", 32'(a_out_valid), 32'h0);
    chk("rst out_pc", 32'(a_out_pc), 32'h0);
    chk("rst out_operand", 32'(a_out_operand), 32'h0);
    a_rst = 0;
    #1;
    chk("first fetch_req", 32'(a_fetch_req), 32'h1);
    chk("first fetch_addr", 32'(a_fetch_addr), 32'h0000);

    // LDA #$05
    wait_entry(0, "e1");
    chk("e1 pc", 32'(a_out_pc), 32'h0000);
    chk("e1 opcode", 32'(a_out_opcode), 32'hA9);
    chk("e1 operand", 32'(a_out_operand), 32'h0005);
    chk("e1 size", 32'(a_out_instr_size), 32'd2);
    chk("e1 reg_dest", 32'(a_out_reg_dest), 32'd1);
    chk("e1 addr_mode", 32'(a_out_addr_mode), 32'd1);
    // ADC #$03 -> ADD (code 1)
    wait_entry(0, "e2");
    chk("e2 pc", 32'(a_out_pc), 32'h0002);
    chk("e2 alu_op", 32'(a_out_alu_op), 32'd1);
    chk("e2 use_alu", 32'(a_out_use_alu), 32'h1);
    chk("e2 operand", 32'(a_out_operand), 32'h0003);
    // INX
    wait_entry(0, "e3");
    chk("e3 pc", 32'(a_out_pc), 32'h0004);
    chk("e3 size", 32'(a_out_instr_size), 32'd1);
    chk("e3 reg_dest", 32'(a_out_reg_dest), 32'd2);
    chk("e3 operand", 32'(a_out_operand), 32'h0000);
    // JMP $1234
    wait_entry(0, "e4");
    chk("e4 pc", 32'(a_out_pc), 32'h0005);
    chk("e4 operand", 32'(a_out_operand), 32'h1234);
    chk("e4 addr_mode", 32'(a_out_addr_mode), 32'd3);
    chk("e4 size", 32'(a_out_instr_size), 32'd3);
    chk("e4 type", 32'(a_out_instr_type), 32'd4);
    // 02 is illegal, single byte
    wait_entry(0, "e5");
    chk("e5 pc", 32'(a_out_pc), 32'h0008);
    chk("e5 illegal", 32'(a_out_illegal), 32'h1);
    chk("e5 size", 32'(a_out_instr_size), 32'd1);
    chk("e5 use_alu", 32'(a_out_use_alu), 32'h0);
    // LDA $2000 follows directly at PC+1
    wait_entry(0, "e6");
    chk("e6 pc", 32'(a_out_pc), 32'h0009);
    chk("e6 opcode", 32'(a_out_opcode), 32'hAD);
    chk("e6 mem_read", 32'(a_out_mem_read), 32'h1);
    chk("e6 operand", 32'(a_out_operand), 32'h2000);
    chk("e6 size", 32'(a_out_instr_size), 32'd3);
    chk("e6 illegal", 32'(a_out_illegal), 32'h0);

    // Flush while the opcode at 0x000C is being returned.
    a_flush = 1; a_flush_pc = 16'h1234;
    #1;
    chk("pre-flush fetch_addr", 32'(a_fetch_addr), 32'h000C);
    chk("pre-flush fetch_req", 32'(a_fetch_req), 32'h1);
    step();
    a_flush = 0; a_out_ready = 0;
    chk("post-flush fetch_addr", 32'(a_fetch_addr), 32'h1234);
    chk("post-flush out_valid", 32'(a_out_valid), 32'h0);

    // Fill the queue with INX entries until fetch stalls in HOLD.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = !a_fetch_req;
    end
    chk("hold reached", 32'(found), 32'h1);
    chk("hold head pc", 32'(a_out_pc), 32'h1234);
    chk("hold fetch_addr", 32'(a_fetch_addr), 32'h1239);
    chk("hold count", 32'(u_a.count_q), 32'd4);
    a_out_ready = 1;
    step();
    a_out_ready = 0;
    chk("pulse head pc", 32'(a_out_pc), 32'h1235);
    chk("pulse fetch_req", 32'(a_fetch_req), 32'h1);
    chk("pulse count", 32'(u_a.count_q), 32'd4);
    step();
    chk("rehold fetch_req", 32'(a_fetch_req), 32'h0);
    chk("rehold fetch_addr", 32'(a_fetch_addr), 32'h123A);
    a_out_ready = 1;
    step();
    chk("drain head pc", 32'(a_out_pc), 32'h1236);

    // ENABLE_ABS=0: AD is illegal and 00 follows at PC+1.
    b_rst = 0;
    wait_entry(1, "b1");
    chk("b1 pc", 32'(b_out_pc), 32'h0000);
    chk("b1 illegal", 32'(b_out_illegal), 32'h1);
    chk("b1 size", 32'(b_out_instr_size), 32'd1);
    chk("b1 mem_read", 32'(b_out_mem_read), 32'h0);
    wait_entry(1, "b2");
    chk("b2 pc", 32'(b_out_pc), 32'h0001);
    chk("b2 opcode", 32'(b_out_opcode), 32'h00);

    // Wrap-around fetch with memory stalls.
    c_rst = 0;
    #1;
    chk("c first fetch_addr", 32'(c_fetch_addr), 32'hFFFE);
    chk("c first fetch_req", 32'(c_fetch_req), 32'h1);
    held = c_fetch_addr;
    stall = 1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (stall) chk("c addr stable", 32'(c_fetch_addr), 32'(held));
      found = c_out_valid;
      if (!found) begin
        c_fetch_valid = (i < 2) ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        held  = c_fetch_addr;
        stall = c_fetch_req && !c_fetch_valid;
      end
    end
    chk("c entry seen", 32'(found), 32'h1);
    chk("c pc", 32'(c_out_pc), 32'hFFFE);
    chk("c operand", 32'(c_out_operand), 32'h0077);
    chk("c size", 32'(c_out_instr_size), 32'd2);
    chk("c wrapped fetch_addr", 32'(c_fetch_addr), 32'h0000);

    // Reset after the opcode at 0x0000 has been taken.
    c_fetch_valid = 1;
    step();
    c_rst = 1;
    step();
    chk("c rst fetch_req", 32'(c_fetch_req), 32'h0);
    chk("c rst out_valid", 32'(c_out_valid), 32'h0);
    c_rst = 0;
    #1;
    chk("c restart fetch_addr", 32'(c_fetch_addr), 32'hFFFE);
    wait_entry(2, "c2");
    chk("c2 pc", 32'(c_out_pc), 32'hFFFE);
    chk("c2 operand", 32'(c_out_operand), 32'h0077);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
